fp_pipe_skid_reg: RTL and testbench
===================================

// Module: fp_pipe_skid_reg
// PURPOSE
//   Parametrised inter-stage register for the FP ALU pipeline (e.g. classify -> compute).
//   Carries one packed stage bundle of DATA_W bits under a valid/ready handshake.
//   An optional skid entry keeps throughput at one word per cycle while in_ready stays registered.
//   Supports synchronous flush and counts back-pressure stall cycles.
// PARAMETERS
//   DATA_W  94  packed bundle width {sign,denA,denB,op_impl,manA[22:0],manB[22:0],expA[7:0],expB[7:0],calc[27:0]}
//   SKID    1   1: 2-entry skid, in_ready registered; 0: 1-entry, in_ready = ~out_valid | out_ready
//   CNT_W   16  width of the stall counter
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   flush      in   1       synchronous flush: discards all held words
//   in_valid   in   1       upstream word valid
//   in_ready   out  1       stage accepts a word this cycle
//   in_data    in   DATA_W  upstream bundle
//   out_valid  out  1       main entry holds a word
//   out_ready  in   1       downstream accepts a word
//   out_data   out  DATA_W  main entry contents
//   stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//   - Reset (rst_n=0, async): state EMPTY, out_valid=0, out_data=0, skid data=0, stall_cnt=0.
//     in_ready=1 once the stage is EMPTY.
//   - Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   - Latency: 1 cycle. in_data accepted at edge N is visible on out_data after edge N.
//   - Ordering is strictly FIFO. No word is dropped or duplicated, except on flush.
//   - out_data is stable and out_valid stays high while out_valid=1 and out_ready=0.
//   - States (SKID=1):
//     EMPTY: in_ready=1. in_fire -> main<=in_data, go FULL.
//     FULL:  in_ready=1.
//       in_fire & out_fire -> main<=in_data, stay FULL.
//       in_fire only       -> skid<=in_data, go SKID.
//       out_fire only      -> go EMPTY.
//     SKID:  in_ready=0. out_fire -> main<=skid, go FULL. Otherwise hold.
//   - in_ready is a flop output: in_ready = (next_state != SKID).
//   - SKID=0: only EMPTY/FULL exist. in_ready = ~out_valid | out_ready (combinational).
//     Same transitions otherwise.
//   - flush=1 has highest priority. Next state EMPTY, out_valid=0, any in_fire that cycle is discarded.
//     Data registers may keep stale values. stall_cnt is not affected.
//   - out_ready may be asserted while out_valid=0; this is ignored.
//     in_data is don't-care when in_valid=0.
//   - stall_cnt increments by 1 each cycle with out_valid & ~out_ready.
//     It holds at 2^CNT_W-1 and clears only on reset.
//   - Reset asserted mid-transfer: held words are lost. Outputs return to reset values asynchronously.
// TESTING
//   1. Reset: rst_n=0 with in_valid=1 -> out_valid=0, out_data=0, stall_cnt=0; in_ready=1 after release.
//   2. Streaming: out_ready=1, send 0x1..0x8 on consecutive cycles -> same order, 1-cycle latency, no bubbles.
//   3. Back-pressure (SKID=1): out_ready=0, send A, B, C.
//      -> A held on out_data; B in skid; in_ready=0 from the cycle after B; C held upstream.
//      out_ready=1 -> A, B, C in order.
//   4. Stall counter: CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=15.
//   5. Flush: stage in SKID holding A and B, assert flush with in_valid=1 (D).
//      -> next cycle out_valid=0, in_ready=1; A, B, D never appear at the output.
//   6. SKID=0 build: out_valid=1, out_ready=1, in_valid=1 (E) -> in_ready=1 and E fires the same cycle.
//      With out_ready=0 -> in_ready=0.

Source files
------------

// File: rtl/fp_pipe_skid_reg.sv
// fp_pipe_skid_reg: valid/ready inter-stage register for the FP ALU pipeline.
// Carries one packed stage bundle per word. With SKID=1 a second (skid) entry
// absorbs the word that arrives while downstream stalls, which keeps in_ready a
// flop output and still sustains one word per cycle. With SKID=0 the stage is a
// single entry with a combinational in_ready. A synchronous flush drops every
// held word, and a saturating counter records back-pressure stall cycles.
module fp_pipe_skid_reg #(
    parameter int DATA_W = 94,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam bit USE_SKID = (SKID != 0);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                out_valid_r;
    logic [DATA_W-1:0]   main_r;
    logic [DATA_W-1:0]   skid_r;
    logic [CNT_W-1:0]    stall_cnt_r;

    logic                in_fire_s;
    logic                out_fire_s;
    logic                main_ld_in_s;
    logic                main_ld_skid_s;
    logic                skid_ld_s;

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid_r & out_ready;

    // Next-state and data-load decode; flush overrides every transition and load.
    always_comb begin
        state_nxt_s    = state_r;
        main_ld_in_s   = 1'b0;
        main_ld_skid_s = 1'b0;
        skid_ld_s      = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_ld_in_s = 1'b1;
                        state_nxt_s  = ST_FULL;
                    end else begin
                        state_nxt_s  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_fire_s && out_fire_s) begin
                        main_ld_in_s = 1'b1;
                        state_nxt_s  = ST_FULL;
                    end else if (in_fire_s && USE_SKID) begin
                        skid_ld_s    = 1'b1;
                        state_nxt_s  = ST_SKID;
                    end else if (out_fire_s) begin
                        state_nxt_s  = ST_EMPTY;
                    end else begin
                        state_nxt_s  = ST_FULL;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire_s) begin
                        main_ld_skid_s = 1'b1;
                        state_nxt_s    = ST_FULL;
                    end else begin
                        state_nxt_s    = ST_SKID;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register and registered out_valid (high whenever main holds a word).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    // Main entry: loads from upstream or promotes the skid word, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r <= {DATA_W{1'b0}};
        end else if (main_ld_in_s) begin
            main_r <= in_data;
        end else if (main_ld_skid_s) begin
            main_r <= skid_r;
        end else begin
            main_r <= main_r;
        end
    end

    // Skid entry: captures the word accepted while the main entry is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_r <= {DATA_W{1'b0}};
        end else if (skid_ld_s) begin
            skid_r <= in_data;
        end else begin
            skid_r <= skid_r;
        end
    end

    // Saturating stall counter; flush does not touch it, only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    generate
        if (USE_SKID) begin : g_ready_reg
            logic in_ready_r;

            // Registered in_ready: accept unless the coming state has both entries full.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_ready_r <= 1'b1;
                end else begin
                    in_ready_r <= (state_nxt_s != ST_SKID);
                end
            end

            assign in_ready = in_ready_r;
        end else begin : g_ready_comb
            // Single entry: a word can enter when empty or when the held word leaves now.
            assign in_ready = ~out_valid_r | out_ready;
        end
    endgenerate

    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fp_pipe_skid_reg.sv
// Directed, table-driven bench for fp_pipe_skid_reg.
// Instance u_a: SKID=1, CNT_W=4 (streaming, back-pressure, saturation, flush, async reset).
// Instance u_b: SKID=0, CNT_W=16 (combinational in_ready).
module tb_fp_pipe_skid_reg;

    localparam int DW = 94;

    logic          clk;
    logic          rst_n;

    logic          a_fl, a_iv, a_or;
    logic [DW-1:0] a_d;
    logic          a_ir, a_ov;
    logic [DW-1:0] a_od;
    logic [3:0]    a_st;

    logic          b_fl, b_iv, b_or;
    logic [DW-1:0] b_d;
    logic          b_ir, b_ov;
    logic [DW-1:0] b_od;
    logic [15:0]   b_st;

    int errors;
    int checks;

    fp_pipe_skid_reg #(.DATA_W(DW), .SKID(1), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_fl),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .stall_cnt(a_st)
    );

    fp_pipe_skid_reg #(.DATA_W(DW), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_fl),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .stall_cnt(b_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          fl;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_d;
        logic [3:0]    e_st;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic fl, input logic iv, input logic [DW-1:0] d,
                           input logic ordy, input logic e_ir, input logic e_ov,
                           input logic [DW-1:0] e_d, input logic [3:0] e_st);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_d = e_d; v.e_st = e_st;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [DW-1:0] va, vb, vc, vd, ve, vw, e0, e1, e2;
    int            exp_st;

    initial begin
        errors = 0;
        checks = 0;
        va = {30'h15555555, 64'hDEAD_BEEF_0123_4567};
        vb = ~va;
        vc = 94'd1 << 93;
        vd = {DW{1'b1}};
        ve = 94'h0_0000_0000_0000_0000_00E5;
        vw = 94'h3_0000_0000_0000_0000_1234;
        e0 = 94'hE0;
        e1 = 94'h1_0000_0000_0000_0000_00E1;
        e2 = 94'hE2;

        a_fl = 1'b0; a_iv = 1'b1; a_d = va; a_or = 1'b0;
        b_fl = 1'b0; b_iv = 1'b1; b_d = va; b_or = 1'b0;

        // Reset with in_valid high: nothing may be captured
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {127'd0, a_ov}, 128'd0);
        chk("rst_out_data", {34'd0, a_od}, 128'd0);
        chk("rst_stall_cnt", {124'd0, a_st}, 128'd0);
        chk("rst_b_out_valid", {127'd0, b_ov}, 128'd0);
        a_iv = 1'b0; b_iv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {127'd0, a_ir}, 128'd1);
        chk("post_rst_out_valid", {127'd0, a_ov}, 128'd0);

        // Streaming 1..8 with out_ready=1: 1-cycle latency, no bubbles
        for (int k = 1; k <= 8; k++) begin
            add_vec(1'b0, 1'b1, DW'(k), 1'b1, 1'b1, 1'b1, DW'(k), 4'd0);
        end
        add_vec(1'b0, 1'b0, va, 1'b1, 1'b1, 1'b0, va, 4'd0);
        // Back-pressure: A held, B into skid, C held upstream, then drain in order
        add_vec(1'b0, 1'b1, va, 1'b0, 1'b1, 1'b1, va, 4'd0);
        add_vec(1'b0, 1'b1, vb, 1'b0, 1'b0, 1'b1, va, 4'd1);
        add_vec(1'b0, 1'b1, vc, 1'b0, 1'b0, 1'b1, va, 4'd2);
        add_vec(1'b0, 1'b1, vc, 1'b1, 1'b1, 1'b1, vb, 4'd2);
        add_vec(1'b0, 1'b1, vc, 1'b1, 1'b1, 1'b1, vc, 4'd2);
        add_vec(1'b0, 1'b0, vc, 1'b1, 1'b1, 1'b0, vc, 4'd2);

        for (int i = 0; i < tbl.size(); i++) begin
            a_fl = tbl[i].fl; a_iv = tbl[i].iv; a_d = tbl[i].d; a_or = tbl[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_in_ready", i), {127'd0, a_ir}, {127'd0, tbl[i].e_ir});
            chk($sformatf("vec%0d_out_valid", i), {127'd0, a_ov}, {127'd0, tbl[i].e_ov});
            if (tbl[i].e_ov) begin
                chk($sformatf("vec%0d_out_data", i), {34'd0, a_od}, {34'd0, tbl[i].e_d});
            end
            chk($sformatf("vec%0d_stall_cnt", i), {124'd0, a_st}, {124'd0, tbl[i].e_st});
        end

        // Stall counter saturation at 15 (CNT_W=4), starting from 2
        a_iv = 1'b1; a_d = vw; a_or = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_load_data", {34'd0, a_od}, {34'd0, vw});
        a_iv = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            exp_st = (2 + k > 15) ? 15 : 2 + k;
            chk($sformatf("sat_stall_%0d", k), {124'd0, a_st}, 128'(exp_st));
            chk($sformatf("sat_hold_data_%0d", k), {34'd0, a_od}, {34'd0, vw});
        end

        // Flush while in SKID with in_valid high: W, B, D all discarded
        a_iv = 1'b1; a_d = vb; a_or = 1'b0;
        @(posedge clk);
        #1;
        chk("skid_in_ready", {127'd0, a_ir}, 128'd0);
        a_fl = 1'b1; a_iv = 1'b1; a_d = vd;
        @(posedge clk);
        #1;
        chk("flush_out_valid", {127'd0, a_ov}, 128'd0);
        chk("flush_in_ready", {127'd0, a_ir}, 128'd1);
        chk("flush_stall_kept", {124'd0, a_st}, 128'd15);
        a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_flush_empty_%0d", k), {127'd0, a_ov}, 128'd0);
        end
        a_iv = 1'b1; a_d = ve;
        @(posedge clk);
        #1;
        chk("post_flush_word", {34'd0, a_od}, {34'd0, ve});
        chk("post_flush_valid", {127'd0, a_ov}, 128'd1);
        a_iv = 1'b0; a_or = 1'b0;
        @(posedge clk);

        // Asynchronous reset mid-transfer: outputs clear without a clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {127'd0, a_ov}, 128'd0);
        chk("async_rst_out_data", {34'd0, a_od}, 128'd0);
        chk("async_rst_stall", {124'd0, a_st}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // SKID=0 build: combinational in_ready, same-cycle accept when draining
        b_iv = 1'b1; b_d = e0; b_or = 1'b0;
        #1;
        chk("b_empty_in_ready", {127'd0, b_ir}, 128'd1);
        @(posedge clk);
        #1;
        chk("b_first_valid", {127'd0, b_ov}, 128'd1);
        chk("b_first_data", {34'd0, b_od}, {34'd0, e0});
        b_d = e1; b_or = 1'b1;
        #1;
        chk("b_drain_in_ready", {127'd0, b_ir}, 128'd1);
        @(posedge clk);
        #1;
        chk("b_same_cycle_data", {34'd0, b_od}, {34'd0, e1});
        chk("b_same_cycle_valid", {127'd0, b_ov}, 128'd1);
        b_d = e2; b_or = 1'b0;
        #1;
        chk("b_stall_in_ready", {127'd0, b_ir}, 128'd0);
        @(posedge clk);
        #1;
        chk("b_hold_data", {34'd0, b_od}, {34'd0, e1});
        chk("b_stall_cnt1", {112'd0, b_st}, 128'd1);
        @(posedge clk);
        #1;
        chk("b_stall_cnt2", {112'd0, b_st}, 128'd2);
        b_iv = 1'b0; b_or = 1'b1;
        @(posedge clk);
        #1;
        chk("b_drained_valid", {127'd0, b_ov}, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
